program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Control-side sequencer that fills CPU RAM from a byte stream, such as the UART receiver or the switch-entry front end, before the CPU runs.
- On request it halts the CPU and takes bytes over a valid/ready handshake.
- For each byte it drives the shared 8-bit bus twice:
  - first the address, into the memory address register;
  - then the data, into RAM.
- When the last byte is written it pulses a CPU reset and releases the halt.
- It sits beside the control unit in top; its bus drive is OR-muxed onto the bus only while `bus_drive` is high.

Parameters:
- ADDR_WIDTH, 4: RAM address width; 16 locations.
- DATA_WIDTH, 8: bus and RAM word width.
- PROG_BYTES, 16: bytes per load. Legal range is 1..2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock. All logic runs on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_req  in  1  start a load. Sampled only in IDLE; level or pulse both work.
- abort  in  1  cancel an in-progress load. Sampled every cycle.
- in_data  in  DATA_WIDTH  incoming program byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- bus_out  out  DATA_WIDTH  value the loader drives onto the shared bus.
- bus_drive  out  1  loader owns the bus this cycle.
- mar_load  out  1  memory address register reads from the bus.
- ram_write  out  1  RAM writes the bus value at the MAR address.
- cpu_halt  out  1  hold the CPU clock and control unit.
- cpu_rst  out  1  one-cycle CPU reset pulse after a successful load.
- busy  out  1  a load is in progress.
- done  out  1  sticky: the last load completed. Cleared by the next load_req or by reset.
- byte_count  out  ADDR_WIDTH+1  number of bytes written in the current or last load.

Behaviour:
- States: IDLE, WAIT_BYTE, SET_ADDR, WRITE_DATA, NEXT, FINISH.
- Outputs are Moore, decoded from the registered state plus the addr/data registers. The only exception is in_ready, which is a pure decode of state == WAIT_BYTE.
- Reset (rst_n low at a clock edge):
  - state = IDLE; addr = 0; data = 0; byte_count = 0; done = 0.
  - All strobes are 0: bus_drive, mar_load, ram_write, cpu_rst, in_ready, busy.
  - cpu_halt = 0. bus_out = 0.
  - Reset mid-load abandons the load immediately, with no cpu_rst pulse.
- IDLE:
  - cpu_halt = 0 and busy = 0.
  - load_req = 1: go to WAIT_BYTE; addr = 0; byte_count = 0; done = 0.
- WAIT_BYTE:
  - in_ready = 1, cpu_halt = 1, busy = 1.
  - in_valid = 1: capture in_data into the data register and go to SET_ADDR.
  - No timeout; the loader waits indefinitely.
- SET_ADDR (one cycle):
  - bus_drive = 1, bus_out = zero-extended addr, mar_load = 1.
- WRITE_DATA (one cycle):
  - bus_drive = 1, bus_out = data, ram_write = 1.
  - byte_count increments at the end of this cycle.
- NEXT (one cycle):
  - If addr == PROG_BYTES-1, go to FINISH.
  - Otherwise addr++ and go to WAIT_BYTE.
  - addr never wraps.
- FINISH (one cycle):
  - cpu_rst = 1 and cpu_halt = 1.
  - Then go to IDLE and set done = 1.
- Throughput: minimum 4 cycles per byte, i.e. handshake, SET_ADDR, WRITE_DATA, NEXT.
- Latency: the last accepted byte to the cpu_rst pulse is exactly 4 cycles.
- Strobe rules:
  - mar_load and ram_write are never high in the same cycle.
  - bus_drive = 1 exactly when state is SET_ADDR or WRITE_DATA.
- abort:
  - In any non-IDLE state, abort = 1 goes to IDLE next cycle with done = 0 and no cpu_rst.
  - A SET_ADDR/WRITE_DATA strobe already being asserted in the current cycle still completes.
  - abort beats in_valid in the same cycle; the byte is not accepted.
- load_req outside IDLE is ignored. load_req and abort together in IDLE: abort wins, and the loader stays in IDLE.

Decomposition:
- Package loader_pkg holds:
  - enum loader_state_t with the six states;
  - localparam CYCLES_PER_BYTE = 4.
- No sub-module. A single FSM with addr, data and byte_count registers.

Test Plan:
- Reset with rst_n = 0 for 2 cycles while load_req = 1 -> all outputs 0 and state IDLE; after release, load_req starts a load the next cycle.
- PROG_BYTES = 16, stream bytes 0xA0..0xAF with in_valid always high:
  - 16 MAR writes of 0x00..0x0F, each followed by a RAM write of 0xA0..0xAF;
  - cpu_rst pulses once at cycle 64 after the first accept;
  - done = 1 and byte_count = 16 afterwards.
- Randomly stalled in_valid, gaps of 0..5 cycles -> in_ready is held, data is captured only on the handshake, and RAM contents are unchanged versus the no-stall run.
- abort asserted in WRITE_DATA of byte 5 -> that RAM write completes; next cycle IDLE with cpu_halt = 0, done = 0, byte_count = 6, and no cpu_rst.
- load_req asserted during WAIT_BYTE of byte 3 -> no effect: addr continues 3, 4, …
- PROG_BYTES = 1, one byte 0x3C -> MAR 0x00, RAM write 0x3C, then cpu_rst, done = 1, byte_count = 1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types for the program loader: sequencer states and per-byte cycle budget.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitByte,
    StSetAddr,
    StWriteData,
    StNext,
    StFinish
  } loader_state_t;

  localparam int unsigned CYCLES_PER_BYTE = 4;

endpackage

// File: rtl/program_loader.sv
// Fills CPU RAM from a byte stream: each byte drives the bus twice (MAR address, then RAM data),
// then pulses CPU reset and releases the halt.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PROG_BYTES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_req_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] bus_out_o,
  output logic                  bus_drive_o,
  output logic                  mar_load_o,
  output logic                  ram_write_o,
  output logic                  cpu_halt_o,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   byte_count_o
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(PROG_BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   CountOne = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

  loader_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] bus_out_q, bus_out_d;
  logic bus_drive_q, bus_drive_d;
  logic mar_load_q, mar_load_d;
  logic ram_write_q, ram_write_d;
  logic cpu_halt_q, cpu_halt_d;
  logic cpu_rst_q, cpu_rst_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    done_d  = done_q;

    // An abort never cancels a strobe already on the bus, so the write still counts.
    if (state_q == StWriteData) count_d = count_q + CountOne;

    if (abort_i) begin
      state_d = StIdle;
      if (state_q != StIdle) done_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_req_i) begin
            state_d = StWaitByte;
            addr_d  = '0;
            count_d = '0;
            done_d  = 1'b0;
          end
        end
        StWaitByte: begin
          if (in_valid_i) begin
            data_d  = in_data_i;
            state_d = StSetAddr;
          end
        end
        StSetAddr:   state_d = StWriteData;
        StWriteData: state_d = StNext;
        StNext: begin
          if (addr_q == LastAddr) begin
            state_d = StFinish;
          end else begin
            addr_d  = addr_q + AddrOne;
            state_d = StWaitByte;
          end
        end
        StFinish: begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copy matches state_q each cycle.
  always_comb begin
    bus_drive_d = (state_d == StSetAddr) || (state_d == StWriteData);
    mar_load_d  = (state_d == StSetAddr);
    ram_write_d = (state_d == StWriteData);
    cpu_halt_d  = (state_d != StIdle);
    busy_d      = (state_d != StIdle);
    cpu_rst_d   = (state_d == StFinish);
    bus_out_d   = '0;
    if (state_d == StSetAddr) begin
      bus_out_d = DATA_WIDTH'(addr_d);
    end else if (state_d == StWriteData) begin
      bus_out_d = data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      bus_out_q   <= '0;
      bus_drive_q <= 1'b0;
      mar_load_q  <= 1'b0;
      ram_write_q <= 1'b0;
      cpu_halt_q  <= 1'b0;
      cpu_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      count_q     <= count_d;
      done_q      <= done_d;
      bus_out_q   <= bus_out_d;
      bus_drive_q <= bus_drive_d;
      mar_load_q  <= mar_load_d;
      ram_write_q <= ram_write_d;
      cpu_halt_q  <= cpu_halt_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o   = (state_q == StWaitByte);
  assign bus_out_o    = bus_out_q;
  assign bus_drive_o  = bus_drive_q;
  assign mar_load_o   = mar_load_q;
  assign ram_write_o  = ram_write_q;
  assign cpu_halt_o   = cpu_halt_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign byte_count_o = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a 16-byte and a 1-byte instance share the same stimulus.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst_n, load_req, abort, in_valid;
  logic [7:0] in_data;

  logic       in_ready, bus_drive, mar_load, ram_write, cpu_halt, cpu_rst, busy, done;
  logic [7:0] bus_out;
  logic [4:0] byte_count;

  logic       in_ready1, bus_drive1, mar_load1, ram_write1, cpu_halt1, cpu_rst1, busy1, done1;
  logic [7:0] bus_out1;
  logic [4:0] byte_count1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobe_viol = 0;

  // Event logs: bit 8 clear = MAR load, set = RAM write; low byte is the bus value.
  logic [8:0] ev_log[$];
  logic [8:0] ev1_log[$];
  int acc_log[$], rst_log[$], acc1_log[$], rst1_log[$];
  logic [3:0] mar_m;
  logic [7:0] ram_m [16];

  program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PROG_BYTES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_req_i(load_req), .abort_i(abort),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .bus_out_o(bus_out), .bus_drive_o(bus_drive), .mar_load_o(mar_load),
    .ram_write_o(ram_write), .cpu_halt_o(cpu_halt), .cpu_rst_o(cpu_rst),
    .busy_o(busy), .done_o(done), .byte_count_o(byte_count)
  );

  program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PROG_BYTES(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .load_req_i(load_req), .abort_i(abort),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .bus_out_o(bus_out1), .bus_drive_o(bus_drive1), .mar_load_o(mar_load1),
    .ram_write_o(ram_write1), .cpu_halt_o(cpu_halt1), .cpu_rst_o(cpu_rst1),
    .busy_o(busy1), .done_o(done1), .byte_count_o(byte_count1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mar_load) begin
      ev_log.push_back({1'b0, bus_out});
      mar_m <= bus_out[3:0];
    end
    if (ram_write) begin
      ev_log.push_back({1'b1, bus_out});
      ram_m[mar_m] <= bus_out;
    end
    if (in_ready && in_valid && !abort) acc_log.push_back(cyc);
    if (cpu_rst) rst_log.push_back(cyc);
    if (mar_load1) ev1_log.push_back({1'b0, bus_out1});
    if (ram_write1) ev1_log.push_back({1'b1, bus_out1});
    if (in_ready1 && in_valid && !abort) acc1_log.push_back(cyc);
    if (cpu_rst1) rst1_log.push_back(cyc);
    if (cyc > 2 && ((mar_load && ram_write) || (bus_drive !== (mar_load || ram_write)) ||
                    (in_ready && bus_drive)))
      strobe_viol <= strobe_viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load_req = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Returns at the negedge where in_ready is seen high.
  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: in_ready got 0 after 20 cycles, expected 1", name);
    end
  endtask

  task automatic wait_accept(input string name);
    wait_ready(name);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_req = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if ({in_ready, bus_drive, mar_load, ram_write, cpu_halt, cpu_rst, busy, done} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 00000000",
               {in_ready, bus_drive, mar_load, ram_write, cpu_halt, cpu_rst, busy, done});
    end
    vectors++;
    if (bus_out !== 8'h00 || byte_count !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_bus_count: got bus %h count %0d expected 00 / 0", bus_out, byte_count);
    end
    vectors++;
    if ({in_ready1, bus_drive1, cpu_halt1, busy1, done1, byte_count1} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_dut1: got %b expected all zero",
               {in_ready1, bus_drive1, cpu_halt1, busy1, done1, byte_count1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({in_ready, busy, cpu_halt} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_release_load: got ready/busy/halt %b expected 111",
               {in_ready, busy, cpu_halt});
    end
    load_req = 1'b0;
  endtask

  task automatic test_full_load();
    int eb, ab, rb;
    logic [8:0] exp;
    do_reset();
    eb = ev_log.size(); ab = acc_log.size(); rb = rst_log.size();
    start_load();
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(8'hA0 + i);
      in_valid = 1'b1;
      wait_accept("full_accept");
    end
    in_valid = 1'b0;
    repeat (8) tick();
    vectors++;
    if ((ev_log.size() - eb) !== 32) begin
      miscompares++;
      $display("FAIL full_event_count: got %0d expected 32", ev_log.size() - eb);
    end else begin
      for (int i = 0; i < 16; i++) begin
        exp = {1'b0, 8'(i)};
        vectors++;
        if (ev_log[eb + 2 * i] !== exp) begin
          miscompares++;
          $display("FAIL full_mar[%0d]: got %h expected %h", i, ev_log[eb + 2 * i], exp);
        end
        exp = {1'b1, 8'(8'hA0 + i)};
        vectors++;
        if (ev_log[eb + 2 * i + 1] !== exp) begin
          miscompares++;
          $display("FAIL full_ram[%0d]: got %h expected %h", i, ev_log[eb + 2 * i + 1], exp);
        end
      end
    end
    vectors++;
    if ((rst_log.size() - rb) !== 1) begin
      miscompares++;
      $display("FAIL full_cpu_rst_count: got %0d expected 1", rst_log.size() - rb);
    end else begin
      vectors++;
      if ((rst_log[rb] - acc_log[ab]) !== 64) begin
        miscompares++;
        $display("FAIL full_cpu_rst_cycle: got %0d expected 64", rst_log[rb] - acc_log[ab]);
      end
    end
    vectors++;
    if ({done, busy, cpu_halt} !== 3'b100 || byte_count !== 5'd16) begin
      miscompares++;
      $display("FAIL full_final: got done/busy/halt %b count %0d expected 100 / 16",
               {done, busy, cpu_halt}, byte_count);
    end
  endtask

  task automatic test_stall();
    int eb;
    int gap;
    logic [7:0] exp;
    do_reset();
    eb = ev_log.size();
    in_valid = 1'b0;
    in_data = 8'hFF;
    start_load();
    for (int i = 0; i < 16; i++) begin
      wait_ready("stall_ready");
      gap = $urandom_range(0, 5);
      repeat (gap) begin
        tick();
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold byte %0d: in_ready got %b expected 1", i, in_ready);
        end
      end
      #1;
      in_data = 8'(8'hA0 + i);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data = 8'hFF;
    end
    repeat (8) tick();
    vectors++;
    if ((ev_log.size() - eb) !== 32) begin
      miscompares++;
      $display("FAIL stall_event_count: got %0d expected 32", ev_log.size() - eb);
    end
    for (int i = 0; i < 16; i++) begin
      exp = 8'(8'hA0 + i);
      vectors++;
      if (ram_m[i] !== exp) begin
        miscompares++;
        $display("FAIL stall_ram[%0d]: got %h expected %h", i, ram_m[i], exp);
      end
    end
    vectors++;
    if (done !== 1'b1 || byte_count !== 5'd16) begin
      miscompares++;
      $display("FAIL stall_final: got done %b count %0d expected 1 / 16", done, byte_count);
    end
  endtask

  task automatic test_abort();
    int eb, rb;
    do_reset();
    eb = ev_log.size(); rb = rst_log.size();
    start_load();
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'hA0 + i);
      in_valid = 1'b1;
      wait_accept("abort_accept");
    end
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    @(negedge clk);
    vectors++;
    if (ram_write !== 1'b1 || bus_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL abort_write_completes: got wr %b bus %h expected 1 / a5", ram_write, bus_out);
    end
    tick();
    abort = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, cpu_halt, done, in_ready, bus_drive} !== 5'b00000 || byte_count !== 5'd6) begin
      miscompares++;
      $display("FAIL abort_idle: got busy/halt/done/rdy/drv %b count %0d expected 00000 / 6",
               {busy, cpu_halt, done, in_ready, bus_drive}, byte_count);
    end
    repeat (6) tick();
    vectors++;
    if ((rst_log.size() - rb) !== 0 || (ev_log.size() - eb) !== 12) begin
      miscompares++;
      $display("FAIL abort_no_rst: got rst %0d events %0d expected 0 / 12",
               rst_log.size() - rb, ev_log.size() - eb);
    end
  endtask

  task automatic test_abort_priority();
    int eb;
    do_reset();
    eb = ev_log.size();
    load_req = 1'b1;
    abort = 1'b1;
    tick();
    load_req = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_beats_load_req: got busy %b ready %b expected 0 / 0", busy, in_ready);
    end
    tick();
    start_load();
    in_data = 8'h55;
    in_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_beats_valid: got busy %b ready %b expected 0 / 0", busy, in_ready);
    end
    repeat (4) tick();
    vectors++;
    if ((ev_log.size() - eb) !== 0) begin
      miscompares++;
      $display("FAIL abort_no_bus: got %0d bus events expected 0", ev_log.size() - eb);
    end
  endtask

  task automatic test_load_req_ignored();
    int eb;
    logic [8:0] exp;
    do_reset();
    eb = ev_log.size();
    start_load();
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'hB0 + i);
      in_valid = 1'b1;
      wait_accept("ignore_accept");
    end
    in_valid = 1'b0;
    wait_ready("ignore_ready");
    #1;
    load_req = 1'b1;
    tick();
    tick();
    load_req = 1'b0;
    for (int i = 3; i < 6; i++) begin
      in_data = 8'(8'hB0 + i);
      in_valid = 1'b1;
      wait_accept("ignore_accept");
    end
    in_valid = 1'b0;
    repeat (4) tick();
    vectors++;
    if ((ev_log.size() - eb) !== 12) begin
      miscompares++;
      $display("FAIL ignore_event_count: got %0d expected 12", ev_log.size() - eb);
    end else begin
      for (int i = 0; i < 6; i++) begin
        exp = {1'b0, 8'(i)};
        vectors++;
        if (ev_log[eb + 2 * i] !== exp) begin
          miscompares++;
          $display("FAIL ignore_mar[%0d]: got %h expected %h", i, ev_log[eb + 2 * i], exp);
        end
      end
    end
    vectors++;
    if (busy !== 1'b1 || byte_count !== 5'd6) begin
      miscompares++;
      $display("FAIL ignore_still_busy: got busy %b count %0d expected 1 / 6", busy, byte_count);
    end
  endtask

  task automatic test_single_byte();
    int e1b, a1b, r1b;
    do_reset();
    e1b = ev1_log.size(); a1b = acc1_log.size(); r1b = rst1_log.size();
    start_load();
    in_data = 8'h3C;
    in_valid = 1'b1;
    wait_accept("single_accept");
    in_valid = 1'b0;
    repeat (6) tick();
    vectors++;
    if ((ev1_log.size() - e1b) !== 2) begin
      miscompares++;
      $display("FAIL single_event_count: got %0d expected 2", ev1_log.size() - e1b);
    end else begin
      vectors++;
      if (ev1_log[e1b] !== 9'h000 || ev1_log[e1b + 1] !== 9'h13C) begin
        miscompares++;
        $display("FAIL single_events: got %h %h expected 000 13c", ev1_log[e1b], ev1_log[e1b + 1]);
      end
    end
    vectors++;
    if ((rst1_log.size() - r1b) !== 1) begin
      miscompares++;
      $display("FAIL single_cpu_rst_count: got %0d expected 1", rst1_log.size() - r1b);
    end else begin
      vectors++;
      if ((rst1_log[r1b] - acc1_log[a1b]) !== 4) begin
        miscompares++;
        $display("FAIL single_latency: got %0d expected 4", rst1_log[r1b] - acc1_log[a1b]);
      end
    end
    vectors++;
    if ({done1, busy1, cpu_halt1} !== 3'b100 || byte_count1 !== 5'd1) begin
      miscompares++;
      $display("FAIL single_final: got done/busy/halt %b count %0d expected 100 / 1",
               {done1, busy1, cpu_halt1}, byte_count1);
    end
  endtask

  task automatic test_strobe_rules();
    vectors++;
    if (strobe_viol !== 0) begin
      miscompares++;
      $display("FAIL strobe_rules: got %0d bad cycles expected 0", strobe_viol);
    end
  endtask

  initial begin
    rst_n = 1'b0; load_req = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_full_load();
    test_stall();
    test_abort();
    test_abort_priority();
    test_load_req_ignored();
    test_single_byte();
    test_strobe_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
